// File: rtl/button_pkg.sv
// Shared definitions for the push-button conditioning slice.
//   chan_state_t             : per-channel debounce FSM state (2-bit encoding)
//   DEFAULT_DEBOUNCE_CYCLES  : stable samples needed to accept an edge (10 ms @ 100 MHz)
package button_pkg;

   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

   typedef enum logic [1:0] {
      IDLE         = 2'b00,
      PRESS_WAIT   = 2'b01,
      PRESSED      = 2'b10,
      RELEASE_WAIT = 2'b11
   } chan_state_t;

endpackage : button_pkg

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM and saturating counter.
//   sysClk  : system clock
//   iRst_n  : synchronous active-low reset
//   raw     : asynchronous raw button, active-high
//   pulse   : registered one-cycle pulse on an accepted press
//   level   : registered debounced held state
module debounce_channel
   import button_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic sysClk,
   input  logic iRst_n,
   input  logic raw,
   output logic pulse,
   output logic level
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q;
   logic             sync_s;
   chan_state_t      state;
   logic [CNT_W-1:0] count;

   assign sync_s = sync_q[1];

   // Bring the raw button into the sysClk domain
   always_ff @(posedge sysClk) begin
      if (!iRst_n) sync_q <= 2'b00;
      else         sync_q <= {sync_q[0], raw};
   end

   // Debounce FSM; the counter only advances while below CNT_LAST, so it never wraps
   always_ff @(posedge sysClk) begin
      if (!iRst_n) begin
         state <= IDLE;
         count <= '0;
         pulse <= 1'b0;
         level <= 1'b0;
      end else begin
         pulse <= 1'b0;
         case (state)
            IDLE: begin
               count <= '0;
               if (sync_s) state <= PRESS_WAIT;
            end
            PRESS_WAIT: begin
               if (!sync_s) begin
                  state <= IDLE;
                  count <= '0;
               end else if (count == CNT_LAST) begin
                  state <= PRESSED;
                  count <= '0;
                  pulse <= 1'b1;
                  level <= 1'b1;
               end else begin
                  count <= count + CNT_W'(1);
               end
            end
            PRESSED: begin
               count <= '0;
               level <= 1'b1;
               if (!sync_s) state <= RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
               if (sync_s) begin
                  state <= PRESSED;
                  count <= '0;
               end else if (count == CNT_LAST) begin
                  state <= IDLE;
                  count <= '0;
                  level <= 1'b0;
               end else begin
                  count <= count + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               count <= '0;
               level <= 1'b0;
            end
         endcase
      end
   end

endmodule : debounce_channel

// File: rtl/button_conditioner.sv
// Conditions the confirm and clear buttons for the draw/recognise controller.
//   sysClk        : system clock
//   iRst_n        : synchronous active-low reset
//   confirm_raw   : raw confirm button (async, active-high)
//   clear_raw     : raw clear button (async, active-high)
//   confirm_pulse : one-cycle confirm press, suppressed while clear is pressing/held
//   clear_pulse   : one-cycle clear press
//   confirm_level : debounced confirm held state
//   clear_level   : debounced clear held state
module button_conditioner
   import button_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic sysClk,
   input  logic iRst_n,
   input  logic confirm_raw,
   input  logic clear_raw,
   output logic confirm_pulse,
   output logic clear_pulse,
   output logic confirm_level,
   output logic clear_level
);

   logic conf_pulse_r;
   logic clr_pulse_r;

   debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_confirm (
      .sysClk (sysClk),
      .iRst_n (iRst_n),
      .raw    (confirm_raw),
      .pulse  (conf_pulse_r),
      .level  (confirm_level)
   );

   debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
      .sysClk (sysClk),
      .iRst_n (iRst_n),
      .raw    (clear_raw),
      .pulse  (clr_pulse_r),
      .level  (clear_level)
   );

   // Clear wins: a confirm press coinciding with or during a clear press is dropped
   assign clear_pulse   = clr_pulse_r;
   assign confirm_pulse = conf_pulse_r & ~clr_pulse_r & ~clear_level;

endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with DEBOUNCE_CYCLES = 4 (press/release latency 6 cycles).
module tb_button_conditioner;

   localparam int unsigned DEB = 4;

   logic sysClk;
   logic iRst_n;
   logic confirm_raw;
   logic clear_raw;
   logic confirm_pulse;
   logic clear_pulse;
   logic confirm_level;
   logic clear_level;

   int checks = 0;
   int errors = 0;
   int seg_idx = 0;

   typedef struct {
      logic       rst_n;
      logic       conf;
      logic       clr;
      int         n;
      logic [3:0] exp;   // {confirm_pulse, clear_pulse, confirm_level, clear_level}
   } seg_t;

   seg_t       segs[$];
   logic [3:0] exp_q[$];
   int         exp_int_q[$];

   button_conditioner #(.DEBOUNCE_CYCLES(DEB)) dut (
      .sysClk        (sysClk),
      .iRst_n        (iRst_n),
      .confirm_raw   (confirm_raw),
      .clear_raw     (clear_raw),
      .confirm_pulse (confirm_pulse),
      .clear_pulse   (clear_pulse),
      .confirm_level (confirm_level),
      .clear_level   (clear_level)
   );

   initial sysClk = 1'b0;
   always #5 sysClk = ~sysClk;

   task automatic add(input logic r, input logic c, input logic k, input int n, input logic [3:0] e);
      seg_t s;
      s.rst_n = r; s.conf = c; s.clr = k; s.n = n; s.exp = e;
      segs.push_back(s);
   endtask

   // Drive one cycle of inputs, expect outputs right after the sampling edge
   task automatic step(input logic r, input logic c, input logic k, input logic [3:0] e);
      logic [3:0] act;
      logic [3:0] want;
      @(negedge sysClk);
      iRst_n = r; confirm_raw = c; clear_raw = k;
      exp_q.push_back(e);
      @(posedge sysClk);
      #1;
      act  = {confirm_pulse, clear_pulse, confirm_level, clear_level};
      want = exp_q.pop_front();
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL seg%0d outputs(cp,kp,cl,kl): got %b expected %b at %0t", seg_idx, act, want, $time);
      end
   endtask

   task automatic drive_only(input logic c, input logic k);
      @(negedge sysClk);
      iRst_n = 1'b1; confirm_raw = c; clear_raw = k;
      @(posedge sysClk);
      #1;
   endtask

   initial begin
      int pulses;
      int lat;
      int got;

      iRst_n = 1'b0; confirm_raw = 1'b0; clear_raw = 1'b0;

      // reset and idle
      add(0,0,0,3,4'b0000);
      add(1,0,0,3,4'b0000);
      // clean press, held 20 cycles
      add(1,1,0,6,4'b0000); add(1,1,0,1,4'b1010); add(1,1,0,13,4'b0010);
      add(1,0,0,6,4'b0010); add(1,0,0,4,4'b0000);
      // single-cycle glitch
      add(1,1,0,1,4'b0000); add(1,0,0,6,4'b0000);
      // press bounce then hold
      add(1,1,0,2,4'b0000); add(1,0,0,2,4'b0000); add(1,1,0,2,4'b0000); add(1,0,0,2,4'b0000);
      add(1,1,0,6,4'b0000); add(1,1,0,1,4'b1010); add(1,1,0,3,4'b0010);
      // release bounce while pressed, then clean release
      add(1,0,0,2,4'b0010); add(1,1,0,6,4'b0010); add(1,0,0,6,4'b0010); add(1,0,0,3,4'b0000);
      // simultaneous presses
      add(1,1,1,6,4'b0000); add(1,1,1,1,4'b0111); add(1,1,1,3,4'b0011);
      add(1,0,0,6,4'b0011); add(1,0,0,2,4'b0000);
      // confirm during held clear
      add(1,0,1,6,4'b0000); add(1,0,1,1,4'b0101); add(1,0,1,3,4'b0001);
      add(1,1,1,6,4'b0001); add(1,1,1,1,4'b0011); add(1,1,1,3,4'b0011);
      add(1,0,0,6,4'b0011); add(1,0,0,2,4'b0000);
      // reset mid-press with button held through reset
      add(1,1,0,3,4'b0000); add(0,1,0,1,4'b0000); add(1,1,0,6,4'b0000);
      add(1,1,0,1,4'b1010); add(1,1,0,2,4'b0010); add(1,0,0,6,4'b0010); add(1,0,0,2,4'b0000);

      for (int i = 0; i < segs.size(); i++) begin
         seg_idx = i;
         for (int j = 0; j < segs[i].n; j++)
            step(segs[i].rst_n, segs[i].conf, segs[i].clr, segs[i].exp);
      end

      // long hold yields exactly one pulse
      pulses = 0;
      exp_int_q.push_back(1);
      for (int i = 0; i < 40; i++) begin
         drive_only(1'b1, 1'b0);
         if (confirm_pulse) pulses++;
      end
      got = exp_int_q.pop_front();
      checks++;
      if (pulses != got) begin
         errors++;
         $display("FAIL long_hold_pulses: got %0d expected %0d", pulses, got);
      end

      // release latency measured in edges after the first low sample
      lat = -1;
      exp_int_q.push_back(int'(DEB) + 2);
      for (int i = 0; i < 20; i++) begin
         drive_only(1'b0, 1'b0);
         if (!confirm_level) begin
            lat = i;
            break;
         end
      end
      got = exp_int_q.pop_front();
      checks++;
      if (lat != got) begin
         errors++;
         $display("FAIL release_latency: got %0d expected %0d", lat, got);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_button_conditioner
